// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, issues one imem request at a time and buffers the word for decode.
// Optional exception redirect to EXC_PC is compiled in with `define FETCH_EXCEPTION_EN.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] EXC_PC   = 32'h0000_0180
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imemReqValid,
    input  logic        imemReqReady,
    output logic [31:0] imemAddr,
    input  logic        imemRespValid,
    input  logic [31:0] imemRespData,
    output logic        instValid,
    input  logic        instReady,
    output logic [31:0] instruction,
    output logic [31:0] instPC,
    input  logic        redirectValid,
    input  logic [31:0] redirectPC,
    input  logic        excValid,
    output logic [31:0] fetchPC
);

    localparam logic [1:0] S_START = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic        r_kill;
    logic [31:0] r_instruction;
    logic [31:0] r_inst_pc;

    logic [1:0]  w_state_next;
    logic [31:0] w_pc_next;
    logic        w_kill_next;
    logic        w_latch;
    logic        w_redir;
    logic [31:0] w_target;
    logic        w_unused;

`ifdef FETCH_EXCEPTION_EN
    // Exception wins over a simultaneous branch/jump redirect.
    assign w_redir  = excValid | redirectValid;
    assign w_target = excValid ? EXC_PC : {redirectPC[31:2], 2'b00};
    assign w_unused = ^redirectPC[1:0];
`else
    assign w_redir  = redirectValid;
    assign w_target = {redirectPC[31:2], 2'b00};
    assign w_unused = ^{excValid, redirectPC[1:0]};
`endif

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_kill_next  = r_kill;
        w_latch      = 1'b0;
        case (r_state)
            S_START: w_state_next = S_REQ;
            S_REQ: begin
                if (w_redir) begin
                    w_pc_next = w_target;
                end
                // A request accepted alongside a redirect is wrong-path: mark it for discard.
                if (imemReqReady) begin
                    w_state_next = S_WAIT;
                    w_kill_next  = w_redir;
                end
            end
            S_WAIT: begin
                if (imemRespValid) begin
                    w_kill_next  = 1'b0;
                    w_state_next = S_REQ;
                    if (w_redir) begin
                        w_pc_next = w_target;
                    end else if (!r_kill) begin
                        w_latch      = 1'b1;
                        w_pc_next    = r_pc + 32'd4;
                        w_state_next = S_OUT;
                    end
                end else if (w_redir) begin
                    w_kill_next = 1'b1;
                    w_pc_next   = w_target;
                end
            end
            S_OUT: begin
                if (w_redir) begin
                    w_pc_next    = w_target;
                    w_state_next = S_REQ;
                end else if (instReady) begin
                    w_state_next = S_REQ;
                end
            end
            default: w_state_next = S_START;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_START;
            r_pc          <= RESET_PC;
            r_kill        <= 1'b0;
            r_instruction <= 32'd0;
            r_inst_pc     <= 32'd0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_kill  <= w_kill_next;
            if (w_latch) begin
                r_instruction <= imemRespData;
                r_inst_pc     <= r_pc;
            end
        end
    end

    assign imemReqValid = (r_state == S_REQ);
    assign instValid    = (r_state == S_OUT);
    assign imemAddr     = r_pc;
    assign fetchPC      = r_pc;
    assign instruction  = r_instruction;
    assign instPC       = r_inst_pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed scenarios then randomized traffic against a
// transaction-level model (architectural pc, outstanding request, output slot).
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] EXC_PC   = 32'h0000_0180;
`ifdef FETCH_EXCEPTION_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        imemReqValid;
    logic        imemReqReady;
    logic [31:0] imemAddr;
    logic        imemRespValid;
    logic [31:0] imemRespData;
    logic        instValid;
    logic        instReady;
    logic [31:0] instruction;
    logic [31:0] instPC;
    logic        redirectValid;
    logic [31:0] redirectPC;
    logic        excValid;
    logic [31:0] fetchPC;

    fetch_sequencer #(.RESET_PC(RESET_PC), .EXC_PC(EXC_PC)) dut (
        .clk(clk), .rst(rst),
        .imemReqValid(imemReqValid), .imemReqReady(imemReqReady), .imemAddr(imemAddr),
        .imemRespValid(imemRespValid), .imemRespData(imemRespData),
        .instValid(instValid), .instReady(instReady),
        .instruction(instruction), .instPC(instPC),
        .redirectValid(redirectValid), .redirectPC(redirectPC),
        .excValid(excValid), .fetchPC(fetchPC)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc;
    bit          m_start;
    bit          m_out;
    bit          m_clean;
    int          m_delay;
    logic [31:0] m_req_addr;
    bit          m_slot;
    logic [31:0] m_inst;
    logic [31:0] m_inst_pc;
    int          mem_lat = 0;
    bit          spur_en = 1'b0;

    function automatic logic [31:0] memword(input logic [31:0] a);
        if (a == 32'd0) return 32'h2000_0001;
        return {a[15:0], a[31:16]} ^ 32'hC3D2_E1F0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = RESET_PC;
        m_start = 1'b1;
        m_out   = 1'b0;
        m_clean = 1'b0;
        m_delay = 0;
        m_slot  = 1'b0;
    endtask

    task automatic check_reset_values();
        chk("rst_reqValid", {31'd0, imemReqValid}, 32'd0);
        chk("rst_instValid", {31'd0, instValid}, 32'd0);
        chk("rst_fetchPC", fetchPC, RESET_PC);
        chk("rst_imemAddr", imemAddr, RESET_PC);
        chk("rst_instruction", instruction, 32'd0);
        chk("rst_instPC", instPC, 32'd0);
    endtask

    // One clock cycle: entered and left at a negedge with DUT outputs stable.
    task automatic step(input bit rv, input logic [31:0] rpc, input bit ev, input bit rdy, input bit irdy);
        bit          exp_req, resp, spur, redir, accept;
        logic [31:0] tgt;
        exp_req = !m_start && !m_out && !m_slot;
        chk("fetchPC", fetchPC, m_pc);
        chk("imemAddr", imemAddr, m_pc);
        chk("reqValid", {31'd0, imemReqValid}, {31'd0, exp_req});
        chk("instValid", {31'd0, instValid}, {31'd0, m_slot});
        if (m_slot) begin
            chk("instruction", instruction, m_inst);
            chk("instPC", instPC, m_inst_pc);
        end
        resp = m_out && (m_delay == 0);
        spur = !m_out && spur_en && ($urandom_range(0, 9) == 0);
        redirectValid = rv;
        redirectPC    = rpc;
        excValid      = ev;
        imemReqReady  = rdy;
        instReady     = irdy;
        imemRespValid = resp || spur;
        imemRespData  = resp ? memword(m_req_addr) : $urandom;

        redir  = !m_start && (rv || (EXC_EN && ev));
        tgt    = (EXC_EN && ev) ? EXC_PC : {rpc[31:2], 2'b00};
        accept = exp_req && rdy;
        if (m_slot && (irdy || redir)) m_slot = 1'b0;
        if (resp) begin
            if (m_clean && !redir) begin
                m_slot    = 1'b1;
                m_inst    = memword(m_req_addr);
                m_inst_pc = m_req_addr;
                m_pc      = m_pc + 32'd4;
            end
            m_out = 1'b0;
        end else if (m_out) begin
            if (redir) m_clean = 1'b0;
            m_delay--;
        end
        if (accept) begin
            m_out      = 1'b1;
            m_req_addr = m_pc;
            m_clean    = !redir;
            m_delay    = mem_lat;
        end
        if (redir) m_pc = tgt;
        m_start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        imemRespValid = 1'b0;
    endtask

    task automatic wait_req(input string tag, input bit no_inst);
        int n = 0;
        while (imemReqValid !== 1'b1 && n < 20) begin
            if (no_inst) chk({tag, "_noInst"}, {31'd0, instValid}, 32'd0);
            step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $error("FAIL %s_timeout observed=no_request expected=request", tag);
        end
    endtask

    task automatic wait_inst(input string tag);
        int n = 0;
        while (instValid !== 1'b1 && n < 20) begin
            step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $error("FAIL %s_timeout observed=no_inst expected=inst", tag);
        end
    endtask

    initial begin
        rst = 1'b1;
        imemReqReady = 0; imemRespValid = 0; imemRespData = 0; instReady = 0;
        redirectValid = 0; redirectPC = 0; excValid = 0;
        model_reset();
        #1;
        check_reset_values();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        $display("T%0t reset released", $time);

        // First fetch with zero-latency memory
        wait_req("first_req", 1'b0);
        chk("first_imemAddr", imemAddr, 32'h0);
        wait_inst("first_inst");
        chk("first_instruction", instruction, 32'h2000_0001);
        chk("first_instPC", instPC, 32'h0);
        chk("first_fetchPC", fetchPC, 32'h4);
        $display("T%0t fetch addr=0 inst=%h", $time, instruction);

        // Decode stalls for 5 cycles
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
            chk("stall_instValid", {31'd0, instValid}, 32'd1);
            chk("stall_noReq", {31'd0, imemReqValid}, 32'd0);
            chk("stall_instruction", instruction, 32'h2000_0001);
            chk("stall_fetchPC", fetchPC, 32'h4);
        end
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("after_stall_imemAddr", imemAddr, 32'h4);
        $display("T%0t stall released, next addr=%h", $time, imemAddr);

        // Redirect while waiting on memory
        mem_lat = 2;
        step(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 32'h0000_0103, 1'b0, 1'b0, 1'b1);
        wait_req("wait_redir", 1'b1);
        chk("wait_redir_imemAddr", imemAddr, 32'h0000_0100);
        $display("T%0t redirect in WAIT -> addr=%h", $time, imemAddr);

        // Redirect in REQ without ready, then redirect coinciding with acceptance
        step(1'b1, 32'h0000_0040, 1'b0, 1'b0, 1'b1);
        chk("req_redir_imemAddr", imemAddr, 32'h0000_0040);
        mem_lat = 0;
        step(1'b1, 32'h0000_0080, 1'b0, 1'b1, 1'b1);
        wait_req("accept_redir", 1'b1);
        chk("accept_redir_imemAddr", imemAddr, 32'h0000_0080);
        $display("T%0t redirect on accept -> addr=%h", $time, imemAddr);

        // PC wraparound
        step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1);
        wait_inst("wrap_inst");
        chk("wrap_instPC", instPC, 32'hFFFF_FFFC);
        chk("wrap_fetchPC", fetchPC, 32'h0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("wrap_imemAddr", imemAddr, 32'h0);
        $display("T%0t wrap instPC=%h next addr=%h", $time, instPC, imemAddr);

        // Exception and redirect in the same cycle
        step(1'b1, 32'h0000_0400, 1'b1, 1'b0, 1'b1);
        chk("exc_imemAddr", imemAddr, EXC_EN ? EXC_PC : 32'h0000_0400);
        $display("T%0t exc+redirect -> addr=%h", $time, imemAddr);

        // Reset while a request is outstanding
        mem_lat = 2;
        step(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        rst = 1'b1;
        #1;
        check_reset_values();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        $display("T%0t mid-run reset released", $time);

        // Randomized traffic
        spur_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            mem_lat = $urandom_range(0, 3);
            step($urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 6);
        end
        $display("T%0t random phase done", $time);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
